bist_fail_log: RTL and testbench
================================

BIST_FAIL_LOG -- requirements
Module: bist_fail_log

Interface
REQ-001 Parameter pADDR_WIDTH, default 4, memory address width.
REQ-002 Parameter pDATA_WIDTH, default 2, memory data width.
REQ-003 Parameter pLOG_DEPTH, default 4, fail-log FIFO entries; power of 2, at least 2.
REQ-004 Parameter pCNT_WIDTH, default 8, fail counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset:
- bist_clk    in   1            clock; all state on rising edge
- bist_rst_n  in   1            asynchronous, active-low reset
REQ-006 The block SHALL provide these ports:
- bist_start  in   1            run start pulse; clears log
- bist_cs     in   1            memory chip select from controller
- bist_we     in   1            1=write, 0=read
- bist_addr   in   pADDR_WIDTH  memory address
- bist_pat    in   pDATA_WIDTH  write/expected pattern
- bist_resp   in   pDATA_WIDTH  memory data out, 1-cycle read latency
- log_valid   out  1            head entry available
- log_ready   in   1            consumer accepts head entry
- log_addr    out  pADDR_WIDTH  head entry failing address
- log_exp     out  pDATA_WIDTH  head entry expected data
- log_act     out  pDATA_WIDTH  head entry actual data
- log_full    out  1            FIFO holds pLOG_DEPTH entries
- log_ovf     out  1            sticky: at least one fail dropped
- fail_cnt    out  pCNT_WIDTH   total read mismatches this run

Function
REQ-007 The block SHALL register bist_cs, bist_we, bist_addr and bist_pat once (stage S1) so they align with bist_resp.
REQ-008 A fail SHALL be detected in the cycle where S1 cs=1, S1 we=0 and bist_resp != S1 pat; writes and idle cycles SHALL never detect a fail.
REQ-009 On a fail, the entry {S1 addr, S1 pat, bist_resp} SHALL be pushed at the same rising edge.
- Read issued at cycle N, mismatch seen at N+1, log_valid=1 at N+2.
REQ-010 Pop SHALL occur on a rising edge where log_valid=1 and log_ready=1; log_addr/exp/act SHALL show the oldest entry and hold stable while log_valid=1 and log_ready=0.
REQ-011 Outputs log_addr/exp/act SHALL be 0 when log_valid=0.
REQ-012 A push with the FIFO full and no pop in the same cycle SHALL drop the entry and set log_ovf; existing entries are unchanged.
REQ-013 A push and pop in the same cycle with the FIFO full SHALL both succeed, leaving it full, with log_ovf unchanged.
REQ-014 A push and pop in the same cycle with the FIFO empty is impossible (log_valid=0), so only the push takes effect.
REQ-015 log_ready with the FIFO empty SHALL be ignored.
REQ-016 Read/write pointers SHALL be log2(pLOG_DEPTH)+1 bits and wrap modulo 2*pLOG_DEPTH.
- full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-017 bist_start=1 SHALL, at that edge, empty the FIFO, clear log_ovf, clear fail_cnt and clear the S1 stage.
- It has priority over any simultaneous push or pop.
- A fail in the same cycle is discarded.

Reset
REQ-018 While bist_rst_n=0, the block SHALL force the following, asynchronously:
- pointers 0, S1 stage 0
- log_valid=0, log_full=0, log_ovf=0, fail_cnt=0
- log_addr/exp/act=0
REQ-019 A reset asserted mid-run SHALL discard all logged entries; the first edge after deassertion behaves as idle.

Configuration
REQ-020 Macro BIST_FAIL_CNT_EN SHALL control the fail counter.
- Defined: fail_cnt increments by 1 on every detected fail, including dropped ones.
  - It saturates at 2^pCNT_WIDTH-1.
  - It is cleared by bist_start and by reset.
- Undefined: no counter register is built and fail_cnt is tied to 0.
- FIFO behaviour is identical in both cases.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults: pADDR_WIDTH=4, pDATA_WIDTH=2, pLOG_DEPTH=4):
- Single fail: write 2'b01 to addr 3, read addr 3 with bist_resp=2'b11 -> log_valid=1 two cycles after the read; addr=3, exp=01, act=11, fail_cnt=1.
- Clean run: 16 writes then 16 reads, resp matching -> log_valid stays 0, log_ovf=0, fail_cnt=0.
- Overflow: log_ready=0, 6 failing reads at addrs 0..5 -> log_full=1, log_ovf=1, entries are addrs 0..3, fail_cnt=6 (0 without macro).
- Full push+pop: FIFO full, fail coincides with log_ready=1 -> addr 0 popped, new addr appended, log_full stays 1, log_ovf stays 0.
- Backpressure/wrap: 10 fails with log_ready toggling every cycle -> all 10 entries out in order, no loss, pointers wrap.
- Clear/reset: bist_start or bist_rst_n=0 with 3 entries logged -> log_valid=0 and fail_cnt=0 next cycle (immediately for reset); a fail coincident with bist_start is not logged.

Source files
------------

// File: rtl/bist_fail_log.sv
// ---------------------------------------------------------------------------
// bist_fail_log
//
// Purpose: Watches the memory BIST controller's command stream and the memory
// read data. A read whose returned data differs from the expected pattern is
// captured as a fail entry {address, expected, actual} into a small FIFO,
// which a consumer drains with a valid/ready handshake. Fails that arrive
// while the FIFO is full (and no pop happens in the same cycle) are dropped,
// and a sticky overflow flag records that a drop happened.
//
// Optional feature macro: BIST_FAIL_CNT_EN
//   defined   - fail_cnt counts every detected fail (including dropped ones)
//               and saturates at all-ones
//   undefined - no counter register; fail_cnt is tied to 0
//
// Ports:
//   bist_clk, bist_rst_n  clock (rising edge) / async active-low reset
//   bist_start            run start pulse; empties log, clears flags/counter
//   bist_cs, bist_we      memory command (chip select, 1=write 0=read)
//   bist_addr, bist_pat   command address and write/expected pattern
//   bist_resp             memory read data, one cycle after the read command
//   log_valid/log_ready   head-entry handshake toward the consumer
//   log_addr/exp/act      head entry fields (0 while log_valid=0)
//   log_full              FIFO holds pLOG_DEPTH entries
//   log_ovf               sticky: at least one fail was dropped
//   fail_cnt              read mismatches seen in this run
// ---------------------------------------------------------------------------
module bist_fail_log #(
    parameter int pADDR_WIDTH = 4,
    parameter int pDATA_WIDTH = 2,
    parameter int pLOG_DEPTH  = 4,
    parameter int pCNT_WIDTH  = 8
) (
    input  logic                   bist_clk,
    input  logic                   bist_rst_n,
    input  logic                   bist_start,
    input  logic                   bist_cs,
    input  logic                   bist_we,
    input  logic [pADDR_WIDTH-1:0] bist_addr,
    input  logic [pDATA_WIDTH-1:0] bist_pat,
    input  logic [pDATA_WIDTH-1:0] bist_resp,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [pADDR_WIDTH-1:0] log_addr,
    output logic [pDATA_WIDTH-1:0] log_exp,
    output logic [pDATA_WIDTH-1:0] log_act,
    output logic                   log_full,
    output logic                   log_ovf,
    output logic [pCNT_WIDTH-1:0]  fail_cnt
);

    localparam int LP_IDX_W = $clog2(pLOG_DEPTH);
    localparam int LP_PTR_W = LP_IDX_W + 1;

    // S1: command delayed one cycle to line up with the read data
    logic                   r_s1_cs;
    logic                   r_s1_we;
    logic [pADDR_WIDTH-1:0] r_s1_addr;
    logic [pDATA_WIDTH-1:0] r_s1_pat;

    logic [LP_PTR_W-1:0]    r_wr_ptr;
    logic [LP_PTR_W-1:0]    r_rd_ptr;
    logic                   r_ovf;

    logic [pADDR_WIDTH-1:0] r_mem_addr [pLOG_DEPTH];
    logic [pDATA_WIDTH-1:0] r_mem_exp  [pLOG_DEPTH];
    logic [pDATA_WIDTH-1:0] r_mem_act  [pLOG_DEPTH];

    logic                   w_fail;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [LP_IDX_W-1:0]    w_wr_idx;
    logic [LP_IDX_W-1:0]    w_rd_idx;

    assign w_fail  = r_s1_cs & ~r_s1_we & (bist_resp != r_s1_pat);

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[LP_PTR_W-1] != r_rd_ptr[LP_PTR_W-1]) &&
                     (r_wr_ptr[LP_IDX_W-1:0] == r_rd_ptr[LP_IDX_W-1:0]);

    assign w_wr_idx = r_wr_ptr[LP_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[LP_IDX_W-1:0];

    // A start pulse wins over everything in the same cycle
    assign w_pop  = ~bist_start & ~w_empty & log_ready;
    // When full, a fail can still be stored if the head leaves this cycle
    assign w_push = ~bist_start & w_fail & (~w_full | w_pop);
    assign w_drop = ~bist_start & w_fail & w_full & ~w_pop;

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            r_s1_cs   <= 1'b0;
            r_s1_we   <= 1'b0;
            r_s1_addr <= '0;
            r_s1_pat  <= '0;
        end else if (bist_start) begin
            r_s1_cs   <= 1'b0;
            r_s1_we   <= 1'b0;
            r_s1_addr <= '0;
            r_s1_pat  <= '0;
        end else begin
            r_s1_cs   <= bist_cs;
            r_s1_we   <= bist_we;
            r_s1_addr <= bist_addr;
            r_s1_pat  <= bist_pat;
        end
    end

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else if (bist_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only observed through the empty mux
    always_ff @(posedge bist_clk) begin
        if (w_push) begin
            r_mem_addr[w_wr_idx] <= r_s1_addr;
            r_mem_exp[w_wr_idx]  <= r_s1_pat;
            r_mem_act[w_wr_idx]  <= bist_resp;
        end
    end

`ifdef BIST_FAIL_CNT_EN
    logic [pCNT_WIDTH-1:0] r_fail_cnt;

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            r_fail_cnt <= '0;
        end else if (bist_start) begin
            r_fail_cnt <= '0;
        end else if (w_fail && (r_fail_cnt != {pCNT_WIDTH{1'b1}})) begin
            r_fail_cnt <= r_fail_cnt + pCNT_WIDTH'(1);
        end
    end

    assign fail_cnt = r_fail_cnt;
`else
    assign fail_cnt = '0;
`endif

    assign log_valid = ~w_empty;
    assign log_full  = w_full;
    assign log_ovf   = r_ovf;
    assign log_addr  = w_empty ? '0 : r_mem_addr[w_rd_idx];
    assign log_exp   = w_empty ? '0 : r_mem_exp[w_rd_idx];
    assign log_act   = w_empty ? '0 : r_mem_act[w_rd_idx];

endmodule

// File: tb/tb_bist_fail_log.sv
module tb_bist_fail_log;

    localparam int D = 4;

    logic       bist_clk = 1'b0;
    logic       bist_rst_n;
    logic       bist_start;
    logic       bist_cs;
    logic       bist_we;
    logic [3:0] bist_addr;
    logic [1:0] bist_pat;
    logic [1:0] bist_resp;
    logic       log_valid;
    logic       log_ready;
    logic [3:0] log_addr;
    logic [1:0] log_exp;
    logic [1:0] log_act;
    logic       log_full;
    logic       log_ovf;
    logic [7:0] fail_cnt;

    always #5 bist_clk = ~bist_clk;

    bist_fail_log dut (
        .bist_clk   (bist_clk),
        .bist_rst_n (bist_rst_n),
        .bist_start (bist_start),
        .bist_cs    (bist_cs),
        .bist_we    (bist_we),
        .bist_addr  (bist_addr),
        .bist_pat   (bist_pat),
        .bist_resp  (bist_resp),
        .log_valid  (log_valid),
        .log_ready  (log_ready),
        .log_addr   (log_addr),
        .log_exp    (log_exp),
        .log_act    (log_act),
        .log_full   (log_full),
        .log_ovf    (log_ovf),
        .fail_cnt   (fail_cnt)
    );

    // Reference model: a plain queue of logged fails plus the previous
    // cycle's command (the read whose data arrives this cycle).
    typedef struct packed {
        logic [3:0] a;
        logic [1:0] e;
        logic [1:0] x;
    } entry_t;

    entry_t     q[$];
    bit         m_ovf;
    int         m_cnt;
    bit         p_rd;
    logic [3:0] p_addr;
    logic [1:0] p_pat;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_cnt  = 0;
        p_rd   = 1'b0;
        p_addr = '0;
        p_pat  = '0;
    endfunction

    function automatic void model_edge();
        bit     fail;
        entry_t ent;
        if (bist_start) begin
            model_reset();
            return;
        end
        fail = p_rd && (bist_resp !== p_pat);
        if ((q.size() > 0) && log_ready) void'(q.pop_front());
        if (fail) begin
            if (m_cnt < 255) m_cnt++;
            if (q.size() < D) begin
                ent = {p_addr, p_pat, bist_resp};
                q.push_back(ent);
            end else begin
                m_ovf = 1'b1;
            end
        end
        p_rd   = bist_cs && !bist_we;
        p_addr = bist_addr;
        p_pat  = bist_pat;
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef BIST_FAIL_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        entry_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".valid"}, log_valid, q.size() > 0);
        chk({tag, ".addr"},  log_addr,  h.a);
        chk({tag, ".exp"},   log_exp,   h.e);
        chk({tag, ".act"},   log_act,   h.x);
        chk({tag, ".full"},  log_full,  q.size() == D);
        chk({tag, ".ovf"},   log_ovf,   m_ovf);
        chk({tag, ".cnt"},   fail_cnt,  exp_cnt(m_cnt));
    endtask

    task automatic tick(input string tag);
        @(posedge bist_clk);
        if (bist_rst_n) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic cyc(input bit cs, input bit we, input logic [3:0] a,
                       input logic [1:0] p, input logic [1:0] r,
                       input bit rdy, input bit st, input string tag);
        bist_cs    = cs;
        bist_we    = we;
        bist_addr  = a;
        bist_pat   = p;
        bist_resp  = r;
        log_ready  = rdy;
        bist_start = st;
        tick(tag);
    endtask

    int npop;

    initial begin
        bist_rst_n = 1'b0;
        bist_start = 1'b0;
        bist_cs    = 1'b0;
        bist_we    = 1'b0;
        bist_addr  = '0;
        bist_pat   = '0;
        bist_resp  = '0;
        log_ready  = 1'b0;
        model_reset();
        #13;
        check_all("reset");
        #4 bist_rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, "idle");

        // Single fail: write 01 to addr 3, read it back as 11
        cyc(0, 0, 0, 0, 0, 0, 1, "single.start");
        cyc(1, 1, 3, 2'b01, 0, 0, 0, "single.wr");
        cyc(1, 0, 3, 2'b01, 0, 0, 0, "single.rd");
        chk("single.valid_n1", log_valid, 0);
        cyc(0, 0, 0, 0, 2'b11, 0, 0, "single.resp");
        chk("single.valid_n2", log_valid, 1);
        chk("single.addr", log_addr, 3);
        chk("single.exp", log_exp, 2'b01);
        chk("single.act", log_act, 2'b11);
        chk("single.cnt", fail_cnt, exp_cnt(1));
        cyc(0, 0, 0, 0, 0, 1, 0, "single.pop");
        chk("single.empty", log_valid, 0);

        // Clean run: 16 writes then 16 matching reads
        cyc(0, 0, 0, 0, 0, 0, 1, "clean.start");
        for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), 2'(i), 0, 0, 0, "clean.wr");
        for (int i = 0; i < 16; i++) cyc(1, 0, 4'(i), 2'(i), 2'(i - 1), 0, 0, "clean.rd");
        cyc(0, 0, 0, 0, 2'(15), 0, 0, "clean.tail");
        chk("clean.valid", log_valid, 0);
        chk("clean.ovf", log_ovf, 0);
        chk("clean.cnt", fail_cnt, 0);

        // Overflow: 6 failing reads with no consumer
        cyc(0, 0, 0, 0, 0, 0, 1, "ovf.start");
        for (int i = 0; i < 6; i++) cyc(1, 0, 4'(i), 2'b01, 2'b10, 0, 0, "ovf.rd");
        cyc(0, 0, 0, 0, 2'b10, 0, 0, "ovf.tail");
        chk("ovf.full", log_full, 1);
        chk("ovf.ovf", log_ovf, 1);
        chk("ovf.cnt", fail_cnt, exp_cnt(6));
        for (int i = 0; i < 4; i++) begin
            chk("ovf.head", log_addr, i);
            cyc(0, 0, 0, 0, 0, 1, 0, "ovf.drain");
        end
        chk("ovf.drained", log_valid, 0);

        // Full FIFO: push and pop in the same cycle
        cyc(0, 0, 0, 0, 0, 0, 1, "fpp.start");
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'(i), 2'b01, 2'b10, 0, 0, "fpp.rd");
        cyc(1, 0, 9, 2'b01, 2'b10, 0, 0, "fpp.rd9");
        chk("fpp.full_before", log_full, 1);
        cyc(0, 0, 0, 0, 2'b10, 1, 0, "fpp.both");
        chk("fpp.head", log_addr, 1);
        chk("fpp.full_after", log_full, 1);
        chk("fpp.ovf", log_ovf, 0);
        begin
            int order[4] = '{1, 2, 3, 9};
            for (int i = 0; i < 4; i++) begin
                chk("fpp.order", log_addr, order[i]);
                cyc(0, 0, 0, 0, 0, 1, 0, "fpp.drain");
            end
        end

        // Backpressure and pointer wrap: 10 fails, ready toggling
        cyc(0, 0, 0, 0, 0, 0, 1, "wrap.start");
        npop = 0;
        for (int k = 0; k < 24; k++) begin
            if (log_valid && k[0]) begin
                chk("wrap.order", log_addr, npop);
                npop++;
            end
            if (!k[0] && k < 20)
                cyc(1, 0, 4'(k / 2), 2'b01, 2'b10, k[0], 0, "wrap.rd");
            else
                cyc(0, 0, 0, 0, 2'b10, k[0], 0, "wrap.idle");
        end
        chk("wrap.npop", npop, 10);
        chk("wrap.ovf", log_ovf, 0);

        // Clear by start; a coincident fail is discarded
        cyc(0, 0, 0, 0, 0, 0, 1, "clr.start0");
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'(i), 2'b01, 2'b10, 0, 0, "clr.rd");
        chk("clr.three", log_valid, 1);
        cyc(0, 0, 0, 0, 2'b10, 0, 1, "clr.start");
        chk("clr.valid", log_valid, 0);
        chk("clr.cnt", fail_cnt, 0);
        cyc(0, 0, 0, 0, 2'b10, 0, 0, "clr.after");
        chk("clr.valid_after", log_valid, 0);

        // Asynchronous reset mid-run
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'(i), 2'b01, 2'b10, 0, 0, "rst.rd");
        bist_cs = 1'b0;
        bist_resp = 2'b10;
        #2 bist_rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst.async");
        chk("rst.valid", log_valid, 0);
        chk("rst.cnt", fail_cnt, 0);
        #2 bist_rst_n = 1'b1;
        tick("rst.first");
        chk("rst.first_idle", log_valid, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit         cs, we, rdy, st;
            logic [1:0] r;
            cs  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) == 0);
            rdy = $urandom_range(0, 1);
            st  = ($urandom_range(0, 63) == 0);
            r   = $urandom_range(0, 1) ? p_pat : 2'($urandom);
            cyc(cs, we, 4'($urandom), 2'($urandom), r, rdy, st, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
